// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit that owns the HI/LO pair.
// MULT/MULTU/DIV/DIVU compute their 64-bit result at launch into pending
// registers. HI/LO are updated only when the busy window ends.
// MTHI/MTLO write HI or LO directly in one cycle.
// Optional feature macro: MD_UNIT_MADD_EN. When it is defined, md_op 7 with
// start performs MADD: {HI,LO} += signed(src_a) * signed(src_b).
// When it is undefined, md_op 7 does nothing.
// Handshake: start is a one-cycle request. It is accepted only while busy=0
// and req=0. Once accepted, busy stays high for exactly N cycles.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        rd_hi,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [31:0] md_result
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    state_t             r_state;
    logic               r_busy;
    logic [3:0]         r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_pend_hi;
    logic [31:0]        r_pend_lo;

    logic               w_is_mult;
    logic               w_is_div;
    logic               w_is_madd;
    logic               w_launch;
    logic               w_b_zero;
    logic               w_div_ovf;
    logic [31:0]        w_div_b;
    logic signed [63:0] w_smul;
    logic [63:0]        w_umul;
    logic [31:0]        w_uq;
    logic [31:0]        w_ur;
    logic signed [31:0] w_sq;
    logic signed [31:0] w_sr;
    logic [63:0]        w_res;

    assign w_is_mult = (md_op == 3'd1) || (md_op == 3'd2);
    assign w_is_div  = (md_op == 3'd3) || (md_op == 3'd4);
`ifdef MD_UNIT_MADD_EN
    assign w_is_madd = (md_op == 3'd7);
`else
    assign w_is_madd = 1'b0;
`endif

    assign w_launch = start && !req && !r_busy && (w_is_mult || w_is_div || w_is_madd);

    // Products are formed at full 64-bit width.
    assign w_smul = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
    assign w_umul = {32'd0, src_a} * {32'd0, src_b};

    // Zero divisor and the signed overflow case take fixed results.
    // The real divider sees a harmless divisor of 1 for these cases, so the
    // simulation model never divides by zero or overflows.
    assign w_b_zero  = (src_b == 32'd0);
    assign w_div_ovf = (md_op == 3'd3) && (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
    assign w_div_b   = (w_b_zero || w_div_ovf) ? 32'd1 : src_b;

    assign w_uq = src_a / w_div_b;
    assign w_ur = src_a % w_div_b;
    assign w_sq = $signed(src_a) / $signed(w_div_b);
    assign w_sr = $signed(src_a) % $signed(w_div_b);

    // Select the 64-bit {HI,LO} result for the op being launched.
    always_comb begin
        w_res = 64'd0;
        case (md_op)
            3'd1: w_res = w_smul;
            3'd2: w_res = w_umul;
            3'd3: begin
                if (w_b_zero)       w_res = {src_a, 32'hFFFF_FFFF};
                else if (w_div_ovf) w_res = {32'd0, 32'h8000_0000};
                else                w_res = {w_sr, w_sq};
            end
            3'd4: begin
                if (w_b_zero) w_res = {src_a, 32'hFFFF_FFFF};
                else          w_res = {w_ur, w_uq};
            end
`ifdef MD_UNIT_MADD_EN
            3'd7: w_res = {r_hi, r_lo} + w_smul;
`endif
            default: w_res = 64'd0;
        endcase
    end

    // Control FSM: idle accepts launches and MTHI/MTLO; busy counts down and then commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_cnt     <= 4'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_pend_hi <= w_res[63:32];
                        r_pend_lo <= w_res[31:0];
                        r_cnt     <= w_is_div ? DIV_N : MULT_N;
                        r_busy    <= 1'b1;
                        r_state   <= S_BUSY;
                    end else if (!req && md_op == 3'd5) begin
                        r_hi <= src_a;
                    end else if (!req && md_op == 3'd6) begin
                        r_lo <= src_a;
                    end
                end
                S_BUSY: begin
                    if (r_cnt <= 4'd1) begin
                        r_hi    <= r_pend_hi;
                        r_lo    <= r_pend_lo;
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign hi_o      = r_hi;
    assign lo_o      = r_lo;
    assign md_result = rd_hi ? r_hi : r_lo;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the Execute stage; owns the HI/LO register pair.
- Consumes the E-stage control (md_op, start) and the forwarded rs/rt operands.
- Produces the md_result value that the M pipeline register captures for MFHI/MFLO.
- Exports busy so hazard logic stalls D-stage md-class instructions while an operation runs.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD when enabled); legal range 1..15
DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..15

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
req  input  1  exception/interrupt flush; cancels the E-stage instruction this cycle
start  input  1  one-cycle pulse: launch the multiply/divide op given on md_op
md_op  input  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved/MADD
rd_hi  input  1  md_result select: 1 = HI, 0 = LO
src_a  input  32  rs operand (dividend, multiplicand, MTHI/MTLO data)
src_b  input  32  rt operand (divisor, multiplier)
busy  output  1  operation in progress
hi_o  output  32  architectural HI
lo_o  output  32  architectural LO
md_result  output  32  rd_hi ? hi_o : lo_o, combinational

Behaviour:
- Reset values: busy=0, hi_o=0, lo_o=0, counter=0, pending result=0; md_result therefore reads 0. Reset has priority over every other input and aborts an in-flight op with no HI/LO update.
- Launch: start=1, req=0, busy=0, md_op in {1..4} at edge T.
  - Operands are sampled and the 64-bit result is computed into pending registers.
  - Counter is loaded with N = MULT_CYCLES or DIV_CYCLES.
  - busy is 1 from the cycle after T through N cycles.
  - On the edge ending the last busy cycle, HI/LO are written and busy falls. New values are visible at T+N+1.
- MULT/MULTU: {HI,LO} = signed/unsigned 32x32 -> 64 product.
- DIV/DIVU: LO = quotient, HI = remainder. Signed division truncates toward zero; remainder sign follows the dividend.
- Division boundary cases:
  - Divisor 0 (both DIV and DIVU): LO=32'hFFFF_FFFF, HI=src_a.
  - DIV of 32'h8000_0000 by 32'hFFFF_FFFF: LO=32'h8000_0000, HI=0.
- MTHI/MTLO (md_op 5/6): single-cycle, no start required. HI or LO is written with src_a at the edge. They never assert busy.
- req=1 suppresses every launch and every MTHI/MTLO write in the same cycle. req does NOT abort an op already busy; that op completes normally.
- start, or md_op 5/6, while busy=1: ignored, with no state change. Hazard logic is responsible for preventing this.
- start with md_op 0, 5, 6 or 7 (7 with feature off): start is ignored. md_op 5/6 still act as MTHI/MTLO.
- During busy, hi_o/lo_o/md_result keep their pre-op values. Pending results are never exposed early.
- Counter width is 4 bits. It decrements once per cycle while busy and never wraps below 0.

Optional Feature:
- Macro: MD_UNIT_MADD_EN.
- Defined: md_op 7 with start = MADD, {HI,LO} <= {HI,LO} + signed(src_a)*signed(src_b), modulo 2^64.
  - The HI/LO addend is sampled at launch.
  - Latency is MULT_CYCLES.
- Undefined: md_op 7 is a NOP under all conditions.

Test Plan:
- Reset then idle: hold reset 2 cycles -> busy=0, hi_o=0, lo_o=0, md_result=0.
- MULT -3 * 7: start, md_op=1, a=32'hFFFF_FFFD, b=7 ->
  - busy high exactly 5 cycles;
  - then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFEB;
  - MULTU with same operands -> HI=6, LO=32'hFFFF_FFEB.
- Signed DIV: DIV -7 / 2 -> busy exactly 10 cycles, then LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF.
- Division boundaries:
  - DIVU 5 / 0 -> LO=32'hFFFF_FFFF, HI=5.
  - DIV 32'h8000_0000 / 32'hFFFF_FFFF -> LO=32'h8000_0000, HI=0.
- Flush and collision handling:
  - start with req=1 -> busy stays 0, HI/LO unchanged.
  - req asserted mid-op -> op completes with the correct result.
  - MTLO 32'h1234 issued while busy -> ignored.
  - MTLO 32'h1234 issued idle -> lo_o=32'h1234 next cycle.
- Reset at busy cycle 3 of DIV -> busy=0 next cycle, HI=LO=0. With MD_UNIT_MADD_EN, HI:LO=0:10, MADD 3*4 -> LO=22 after 5 cycles.
